draw_rect_engine: RTL and testbench

Parametrised superpixel rectangle renderer for the VGA frame-buffer RAM. It accepts two corner superpixels in any order, clamps and normalises them, and scans the covered physical pixels in raster order. In fill mode it writes every pixel; in outline mode it writes only a border band of configurable thickness and jumps over the interior. It sits between the user drawing logic and the VGA RAM write port, with a valid/ready command handshake and write back-pressure.

---
 rtl/draw_pkg.sv | 26 ++
 rtl/draw_rect_engine_if.sv | 34 +++
 rtl/rect_scan_gen.sv | 54 +++++
 rtl/draw_rect_engine.sv | 120 ++++++++++++
 tb/tb_draw_rect_engine.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared constants and types for the rectangle renderer
package draw_pkg;

    localparam int DEF_SPIXEL_X_WIDTH = 6;
    localparam int DEF_SPIXEL_Y_WIDTH = 6;
    localparam int DEF_SPIXEL_X_MAX   = 63;
    localparam int DEF_SPIXEL_Y_MAX   = 47;
    localparam int DEF_SCALE          = 10;
    localparam int DEF_PIXEL_X_WIDTH  = 10;
    localparam int DEF_PIXEL_Y_WIDTH  = 9;
    localparam int DEF_H_RES          = 640;
    localparam int DEF_VGA_ADDR_WIDTH = 19;
    localparam int DEF_COLOR_ID_WIDTH = 8;
    localparam int DEF_BORDER         = 1;

    localparam logic MODE_FILL    = 1'b0;
    localparam logic MODE_OUTLINE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_DRAW,
        ST_DONE
    } state_t;

endpackage

// File: rtl/draw_rect_engine_if.sv
// rtl/draw_rect_engine_if.sv - command handshake and frame-buffer write port bundle
interface draw_rect_engine_if
    import draw_pkg::*;
#(
    parameter int SPIXEL_X_WIDTH = DEF_SPIXEL_X_WIDTH,
    parameter int SPIXEL_Y_WIDTH = DEF_SPIXEL_Y_WIDTH,
    parameter int VGA_ADDR_WIDTH = DEF_VGA_ADDR_WIDTH,
    parameter int COLOR_ID_WIDTH = DEF_COLOR_ID_WIDTH
);
    logic [SPIXEL_X_WIDTH-1:0] x0;
    logic [SPIXEL_Y_WIDTH-1:0] y0;
    logic [SPIXEL_X_WIDTH-1:0] x1;
    logic [SPIXEL_Y_WIDTH-1:0] y1;
    logic [COLOR_ID_WIDTH-1:0] icolor;
    logic                      imode;
    logic                      ivalid;
    logic                      iready;
    logic                      owr_ready;
    logic [VGA_ADDR_WIDTH-1:0] oaddr;
    logic [COLOR_ID_WIDTH-1:0] odata;
    logic                      owren;
    logic                      obusy;
    logic                      odone;

    modport master (
        output x0, y0, x1, y1, icolor, imode, ivalid, owr_ready,
        input  iready, oaddr, odata, owren, obusy, odone
    );

    modport slave (
        input  x0, y0, x1, y1, icolor, imode, ivalid, owr_ready,
        output iready, oaddr, odata, owren, obusy, odone
    );
endinterface

// File: rtl/rect_scan_gen.sv
// rtl/rect_scan_gen.sv - raster x/y stepper over a pixel rectangle, with outline interior skip
module rect_scan_gen
    import draw_pkg::*;
#(
    parameter int PIXEL_X_WIDTH = DEF_PIXEL_X_WIDTH,
    parameter int PIXEL_Y_WIDTH = DEF_PIXEL_Y_WIDTH,
    parameter int BORDER        = DEF_BORDER
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PIXEL_X_WIDTH-1:0] tlx,
    input  logic [PIXEL_X_WIDTH-1:0] brx,
    input  logic [PIXEL_Y_WIDTH-1:0] tly,
    input  logic [PIXEL_Y_WIDTH-1:0] bry,
    input  logic                     mode,
    input  logic                     load,
    input  logic                     step,
    output logic [PIXEL_X_WIDTH-1:0] x,
    output logic [PIXEL_Y_WIDTH-1:0] y,
    output logic                     last
);
    logic border_row;
    logic wide;
    logic jump;

    // Skip only when a real interior exists; narrow shapes degrade to a plain fill.
    always_comb begin
        border_row = (32'(y) < 32'(tly) + 32'(BORDER)) ||
                     (32'(y) + 32'(BORDER) > 32'(bry));
        wide       = (32'(brx) - 32'(tlx) + 32'd1) > 32'(2 * BORDER);
        jump       = (mode == MODE_OUTLINE) && !border_row && wide &&
                     (32'(x) == 32'(tlx) + 32'(BORDER) - 32'd1);
        last       = (x == brx) && (y == bry);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (load) begin
            x <= tlx;
            y <= tly;
        end else if (step && !last) begin
            if (x == brx) begin
                x <= tlx;
                y <= y + PIXEL_Y_WIDTH'(1);
            end else if (jump) begin
                x <= brx - PIXEL_X_WIDTH'(BORDER) + PIXEL_X_WIDTH'(1);
            end else begin
                x <= x + PIXEL_X_WIDTH'(1);
            end
        end
    end
endmodule

// File: rtl/draw_rect_engine.sv
// rtl/draw_rect_engine.sv - superpixel rectangle fill/outline renderer feeding the VGA RAM write port
module draw_rect_engine
    import draw_pkg::*;
#(
    parameter int SPIXEL_X_WIDTH = DEF_SPIXEL_X_WIDTH,
    parameter int SPIXEL_Y_WIDTH = DEF_SPIXEL_Y_WIDTH,
    parameter int SPIXEL_X_MAX   = DEF_SPIXEL_X_MAX,
    parameter int SPIXEL_Y_MAX   = DEF_SPIXEL_Y_MAX,
    parameter int SCALE          = DEF_SCALE,
    parameter int PIXEL_X_WIDTH  = DEF_PIXEL_X_WIDTH,
    parameter int PIXEL_Y_WIDTH  = DEF_PIXEL_Y_WIDTH,
    parameter int H_RES          = DEF_H_RES,
    parameter int VGA_ADDR_WIDTH = DEF_VGA_ADDR_WIDTH,
    parameter int COLOR_ID_WIDTH = DEF_COLOR_ID_WIDTH,
    parameter int BORDER         = DEF_BORDER
) (
    input  logic               clk,
    input  logic               rst,
    draw_rect_engine_if.slave  bus
);
    localparam logic [SPIXEL_X_WIDTH-1:0] X_LIM = SPIXEL_X_WIDTH'(SPIXEL_X_MAX);
    localparam logic [SPIXEL_Y_WIDTH-1:0] Y_LIM = SPIXEL_Y_WIDTH'(SPIXEL_Y_MAX);

    state_t state, state_next;

    logic [SPIXEL_X_WIDTH-1:0] x0_r, x1_r, xa, xb, xmin, xmax;
    logic [SPIXEL_Y_WIDTH-1:0] y0_r, y1_r, ya, yb, ymin, ymax;
    logic [COLOR_ID_WIDTH-1:0] color_r;
    logic                      mode_r;

    logic [PIXEL_X_WIDTH-1:0]  tlx, brx, scan_x;
    logic [PIXEL_Y_WIDTH-1:0]  tly, bry, scan_y;
    logic                      scan_last;
    logic                      accept;
    logic                      step;

    assign accept = bus.ivalid && bus.iready;
    assign step   = bus.owren && bus.owr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            x0_r    <= '0;
            y0_r    <= '0;
            x1_r    <= '0;
            y1_r    <= '0;
            color_r <= '0;
            mode_r  <= MODE_FILL;
        end else if (accept) begin
            x0_r    <= bus.x0;
            y0_r    <= bus.y0;
            x1_r    <= bus.x1;
            y1_r    <= bus.y1;
            color_r <= bus.icolor;
            mode_r  <= bus.imode;
        end
    end

    // Bounds are derived from the held command, so they stay stable through DRAW.
    always_comb begin
        xa   = (x0_r > X_LIM) ? X_LIM : x0_r;
        xb   = (x1_r > X_LIM) ? X_LIM : x1_r;
        ya   = (y0_r > Y_LIM) ? Y_LIM : y0_r;
        yb   = (y1_r > Y_LIM) ? Y_LIM : y1_r;
        xmin = (xa < xb) ? xa : xb;
        xmax = (xa < xb) ? xb : xa;
        ymin = (ya < yb) ? ya : yb;
        ymax = (ya < yb) ? yb : ya;
    end

    assign tlx = PIXEL_X_WIDTH'(32'(xmin) * 32'(SCALE));
    assign brx = PIXEL_X_WIDTH'((32'(xmax) + 32'd1) * 32'(SCALE) - 32'd1);
    assign tly = PIXEL_Y_WIDTH'(32'(ymin) * 32'(SCALE));
    assign bry = PIXEL_Y_WIDTH'((32'(ymax) + 32'd1) * 32'(SCALE) - 32'd1);

    rect_scan_gen #(
        .PIXEL_X_WIDTH (PIXEL_X_WIDTH),
        .PIXEL_Y_WIDTH (PIXEL_Y_WIDTH),
        .BORDER        (BORDER)
    ) u_scan (
        .clk  (clk),
        .rst  (rst),
        .tlx  (tlx),
        .brx  (brx),
        .tly  (tly),
        .bry  (bry),
        .mode (mode_r),
        .load (state == ST_SETUP),
        .step (step),
        .x    (scan_x),
        .y    (scan_y),
        .last (scan_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept) state_next = ST_SETUP;
            ST_SETUP: state_next = ST_DRAW;
            ST_DRAW:  if (step && scan_last) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // The scan counter only moves on an accepted write, so the port holds while stalled.
    assign bus.iready = (state == ST_IDLE) && !rst;
    assign bus.obusy  = (state != ST_IDLE);
    assign bus.owren  = (state == ST_DRAW);
    assign bus.odone  = (state == ST_DONE);
    assign bus.odata  = color_r;
    assign bus.oaddr  = VGA_ADDR_WIDTH'(32'(scan_y) * 32'(H_RES) + 32'(scan_x));
endmodule

// File: tb/tb_draw_rect_engine.sv
// tb/tb_draw_rect_engine.sv - directed self-checking bench for draw_rect_engine
module tb_draw_rect_engine;
    import draw_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    int   wq[$];
    int   eq[$];
    int   first_it;
    int   stall_bad;
    int   data_bad;
    int   max_addr;

    always #5 clk = ~clk;

    draw_rect_engine_if bus ();

    draw_rect_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Independent reference: clamp, order, scale, then keep pixels inside the border band.
    task automatic build_exp(input int ax0, input int ay0, input int ax1, input int ay1, input logic md);
        int cx0, cy0, cx1, cy1, tlx, brx, tly, bry;
        eq.delete();
        cx0 = (ax0 > 63) ? 63 : ax0;
        cx1 = (ax1 > 63) ? 63 : ax1;
        cy0 = (ay0 > 47) ? 47 : ay0;
        cy1 = (ay1 > 47) ? 47 : ay1;
        tlx = ((cx0 < cx1) ? cx0 : cx1) * 10;
        brx = (((cx0 < cx1) ? cx1 : cx0) + 1) * 10 - 1;
        tly = ((cy0 < cy1) ? cy0 : cy1) * 10;
        bry = (((cy0 < cy1) ? cy1 : cy0) + 1) * 10 - 1;
        for (int yy = tly; yy <= bry; yy++) begin
            for (int xx = tlx; xx <= brx; xx++) begin
                if (md == 1'b0 || yy < tly + 1 || yy > bry - 1 || xx < tlx + 1 || xx > brx - 1)
                    eq.push_back(yy * 640 + xx);
            end
        end
    endtask

    task automatic cmp_seq(input string tag);
        int bad = 0;
        check({tag, "_count"}, wq.size(), eq.size());
        for (int i = 0; i < wq.size() && i < eq.size(); i++)
            if (wq[i] != eq[i]) bad++;
        check({tag, "_order"}, bad, 0);
    endtask

    // Called at a negedge with the engine idle; returns at the negedge of the first idle cycle after odone.
    task automatic run_cmd(input int ax0, input int ay0, input int ax1, input int ay1,
                           input logic [7:0] col, input logic md, input bit bp);
        int         last_w = -1;
        int         done_at = -1;
        logic [18:0] pa = '0;
        logic [7:0]  pd = '0;
        logic        stalled = 1'b0;
        wq.delete();
        first_it  = -1;
        stall_bad = 0;
        data_bad  = 0;
        max_addr  = 0;
        bus.x0     = 6'(ax0);
        bus.y0     = 6'(ay0);
        bus.x1     = 6'(ax1);
        bus.y1     = 6'(ay1);
        bus.icolor = col;
        bus.imode  = md;
        bus.ivalid = 1'b1;
        check("iready_at_accept", bus.iready, 1);
        @(posedge clk); #1;
        bus.ivalid = 1'b0;
        @(negedge clk);
        check("setup_no_write", bus.owren, 0);
        check("setup_busy", bus.obusy, 1);
        @(posedge clk); #1;
        for (int it = 0; it < 8000; it++) begin
            bus.owr_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (stalled && (bus.oaddr !== pa || bus.odata !== pd || bus.owren !== 1'b1)) stall_bad++;
            if (bus.odone === 1'b1) begin
                done_at = it;
                break;
            end
            if (bus.owren === 1'b1 && first_it < 0) first_it = it;
            if (bus.owren === 1'b1 && bus.owr_ready === 1'b1) begin
                wq.push_back(int'(bus.oaddr));
                if (int'(bus.oaddr) > max_addr) max_addr = int'(bus.oaddr);
                if (bus.odata !== col) data_bad++;
                last_w = it;
            end
            stalled = bus.owren && !bus.owr_ready;
            pa = bus.oaddr;
            pd = bus.odata;
            @(posedge clk); #1;
        end
        bus.owr_ready = 1'b1;
        check("done_seen", done_at >= 0, 1);
        check("done_after_last_write", done_at - last_w, 1);
        @(posedge clk);
        @(negedge clk);
        check("done_one_cycle", bus.odone, 0);
        check("iready_after_done", bus.iready, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
        bus.icolor = '0; bus.imode = MODE_FILL; bus.ivalid = 1'b0;
        bus.owr_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_owren", bus.owren, 0);
        check("rst_oaddr", bus.oaddr, 0);
        check("rst_odata", bus.odata, 0);
        check("rst_odone", bus.odone, 0);
        check("rst_obusy", bus.obusy, 0);
        check("rst_iready", bus.iready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("iready_after_rst", bus.iready, 1);
        check("idle_not_busy", bus.obusy, 0);

        // Fill one superpixel (1,2)
        run_cmd(1, 2, 1, 2, 8'h2A, MODE_FILL, 1'b0);
        build_exp(1, 2, 1, 2, MODE_FILL);
        check("fill_first_latency", first_it, 0);
        check("fill_count", wq.size(), 100);
        check("fill_first_addr", wq[0], 12810);
        check("fill_last_addr", wq[wq.size()-1], 18579);
        check("fill_data", data_bad, 0);
        cmp_seq("fill");

        // Swapped corners, issued in the first idle cycle
        run_cmd(3, 3, 2, 2, 8'h55, MODE_FILL, 1'b0);
        build_exp(2, 2, 3, 3, MODE_FILL);
        check("swap_count", wq.size(), 400);
        check("swap_first_addr", wq[0], 12820);
        check("swap_first_latency", first_it, 0);
        cmp_seq("swap");

        // Outline of a 20x20 block
        run_cmd(0, 0, 1, 1, 8'h07, MODE_OUTLINE, 1'b0);
        build_exp(0, 0, 1, 1, MODE_OUTLINE);
        check("outline_count", wq.size(), 76);
        check("outline_row1_left", wq[20], 640);
        check("outline_row1_right", wq[21], 659);
        check("outline_row19_first", wq[56], 12160);
        check("outline_row19_last", wq[75], 12179);
        check("outline_data", data_bad, 0);
        cmp_seq("outline");

        // Back-pressure on a 100-pixel fill
        run_cmd(1, 2, 1, 2, 8'hC3, MODE_FILL, 1'b1);
        build_exp(1, 2, 1, 2, MODE_FILL);
        check("bp_stall_stable", stall_bad, 0);
        check("bp_data", data_bad, 0);
        cmp_seq("bp");

        // Clamp to the bottom-right corner
        run_cmd(60, 40, 63, 60, 8'hFF, MODE_FILL, 1'b0);
        build_exp(60, 40, 63, 60, MODE_FILL);
        check("clamp_count", wq.size(), 3200);
        check("clamp_last_addr", wq[wq.size()-1], 307199);
        check("clamp_in_range", max_addr < 307200, 1);
        cmp_seq("clamp");

        // Reset in the middle of DRAW
        bus.x0 = 6'd0; bus.y0 = 6'd0; bus.x1 = 6'd2; bus.y1 = 6'd2;
        bus.icolor = 8'h11; bus.imode = MODE_FILL; bus.ivalid = 1'b1;
        @(posedge clk); #1;
        bus.ivalid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("mid_draw_writing", bus.owren, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_owren", bus.owren, 0);
        check("rst_mid_odone", bus.odone, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_iready", bus.iready, 1);
        check("rst_mid_no_done", bus.odone, 0);

        run_cmd(0, 0, 0, 0, 8'h3C, MODE_FILL, 1'b0);
        build_exp(0, 0, 0, 0, MODE_FILL);
        check("post_rst_first_addr", wq[0], 0);
        check("post_rst_data", data_bad, 0);
        cmp_seq("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
